xcore_gnrl_fifo: RTL
====================

Name: xcore_gnrl_fifo

Overview:
General-purpose synchronous FIFO with valid/ready handshakes on both ends. It is the consumer-facing counterpart to the general load-enable register: a writer pushes words, and a reader drains them in order. It is used between CPU pipeline stages (fetch-to-decode, LSU request queue) wherever a single register cannot absorb backpressure. It is a single clock-domain block.

Parameters:
DW, 8, data width in bits (>=1)
DP, 4, depth in entries (>=1, any integer; power of two not required)
CW, $clog2(DP+1), width of the occupancy count (derived; not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset; one clock, sampled on posedge clk
i_vld  input  1  writer has a word on i_dat
i_rdy  output  1  FIFO can accept a word this cycle
i_dat  input  DW  write data
o_vld  output  1  FIFO holds at least one word
o_rdy  input  1  reader accepts o_dat this cycle
o_dat  output  DW  head-of-queue data
count  output  CW  number of stored entries, 0..DP
full  output  1  count == DP
empty  output  1  count == 0

Behaviour:
- push = i_vld & i_rdy; pop = o_vld & o_rdy; both evaluated in the same cycle, take effect at the next posedge.
- Reset (reset==1 at posedge clk): wptr=0, rptr=0, count=0. After reset: i_rdy=1, o_vld=0, o_dat=0, full=0, empty=1. Storage array is not cleared.
- Reset has priority over push/pop in the same cycle. Any in-flight words are discarded, and the push in that cycle is dropped.
- i_rdy = ~full (combinational from registered count). It does not depend on o_rdy, so there is no pass-through when full: a push while full is refused even if a pop occurs in the same cycle.
- o_vld = ~empty. The output comes from registered state only and never combinationally from i_vld.
- Latency: a word pushed into an empty FIFO at edge N is visible (o_vld=1) in the cycle after edge N. There is no same-cycle bypass.
- o_dat = mem[rptr] when o_vld=1, and all-zero when empty (masked output, matching the team's zero-when-not-loaded register convention).
- Pointers: wptr and rptr run 0..DP-1. Each increments on push/pop respectively and wraps from DP-1 to 0 by explicit compare; there is no power-of-two assumption.
- count update: push&~pop -> +1; pop&~push -> -1; push&pop -> unchanged; otherwise unchanged.
- Simultaneous push and pop with 0<count<DP: both pointers advance and count holds. Order is preserved.
- Push and pop in the same cycle when empty: pop is impossible (o_vld=0), so only the push happens.
- DP=1: the block degrades to a single full/empty register. Throughput is at most one word every two cycles, because there is no pass-through.
- Writer protocol: once i_vld=1 with i_rdy=0, the writer holds i_vld and i_dat until accepted. The FIFO does not check this. The reader may drop o_rdy at any time.
- The outputs i_rdy, o_vld, full, empty and count are pure functions of registered state and never glitch on same-cycle inputs.

Decomposition:
- No shared package is required. The only derived constant is CW. Pointer width, $clog2(DP) (min 1), is a localparam.
- Storage is a reg array inside the block.
- One natural sub-module: xcore_gnrl_fifo_ptr, a wrap-at-DP-1 pointer counter with increment enable and sync reset. It is instantiated twice (wptr, rptr).

Test Plan:
- Reset then idle: after reset -> i_rdy=1, o_vld=0, o_dat=0x00, count=0, empty=1, full=0 for 10 cycles.
- Fill/drain, DW=8, DP=4, o_rdy=0: push 0x11,0x22,0x33,0x44 -> full=1, i_rdy=0, count=4; a 5th push of 0x55 is refused. Then o_rdy=1 -> reads 0x11,0x22,0x33,0x44 on consecutive cycles, then empty=1, o_dat=0x00.
- Streaming at count=2: push and pop every cycle for 20 cycles with incrementing data -> count stays 2, output order matches input, and pointers wrap at least 5 times without loss.
- Full with simultaneous pop: at count=4, i_vld=1 and o_rdy=1 -> pop occurs, push refused, count=3; the next cycle the push is accepted.
- Reset mid-operation: at count=3, assert reset for 1 cycle while i_vld=1 -> count=0, o_vld=0, and the pushed word is lost. The next push of 0xA5 appears at o_dat one cycle later.
- DP=1 and DP=3 builds: random valid/ready (50%) for 1000 cycles against a scoreboard -> no loss, no duplication, count within 0..DP, and the DP=3 pointers wrap 2->0.

Source files
------------

// File: rtl/xcore_gnrl_fifo_pkg.sv
// Shared helpers for the general-purpose FIFO.
// ptr_w: pointer width for a given depth, never less than one bit.
package xcore_gnrl_fifo_pkg;

    function automatic int ptr_w(input int dp);
        return (dp > 1) ? $clog2(dp) : 1;
    endfunction

endpackage

// File: rtl/xcore_gnrl_fifo_ptr.sv
// Wrap-at-DP-1 pointer counter with increment enable.
// Ports:
//   clk    clock, updates on rising edge
//   reset  synchronous active-high reset, clears ptr to 0
//   inc    advance the pointer this cycle
//   ptr    current pointer value, 0..DP-1
module xcore_gnrl_fifo_ptr
    import xcore_gnrl_fifo_pkg::*;
#(
    parameter  int DP = 4,
    localparam int PW = ptr_w(DP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DP - 1);

    // Explicit compare against the last slot so any depth works, not just
    // powers of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/xcore_gnrl_fifo.sv
// General-purpose synchronous FIFO with valid/ready on both ends.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (pointers and count cleared)
//   i_vld  writer has a word on i_dat
//   i_rdy  FIFO can accept a word (not full)
//   i_dat  write data
//   o_vld  FIFO holds at least one word
//   o_rdy  reader accepts o_dat
//   o_dat  head-of-queue data, zero when empty
//   count  number of stored entries, 0..DP
//   full   count == DP
//   empty  count == 0
module xcore_gnrl_fifo
    import xcore_gnrl_fifo_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int DP = 4,
    localparam int CW = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = ptr_w(DP);

    logic [DW-1:0] mem [DP];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push;
    logic          pop;

    // Handshake outputs come only from the registered count, so a full FIFO
    // refuses a push even when a pop happens in the same cycle.
    assign full  = (count == CW'(DP));
    assign empty = (count == '0);
    assign i_rdy = ~full;
    assign o_vld = ~empty;
    assign push  = i_vld & i_rdy;
    assign pop   = o_vld & o_rdy;

    // Head is masked to zero when nothing is stored.
    assign o_dat = o_vld ? mem[rptr] : '0;

    xcore_gnrl_fifo_ptr #(.DP(DP)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .ptr   (wptr)
    );

    xcore_gnrl_fifo_ptr #(.DP(DP)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .ptr   (rptr)
    );

    // Storage is not cleared on reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= i_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

endmodule
